spi_burst_sequencer: RTL and testbench

Byte-burst front end for the SPI master. Buffers host TX bytes in a FIFO, issues one SPI byte transaction per byte for a commanded burst length, and buffers the received bytes in an RX FIFO for the host. Sits directly upstream of the SPI master: it drives the master's start/tx-data inputs and consumes its rx-data/done outputs.

---
 rtl/spi_burst_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_sequencer.sv
// Byte-burst front end for an SPI master: TX byte FIFO, per-byte transaction
// sequencing for a commanded burst length, and an RX byte FIFO for the host.
module spi_burst_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tx_valid_i,
  output logic                       tx_ready_o,
  input  logic [7:0]                 tx_byte_i,
  output logic [$clog2(DEPTH):0]     tx_level_o,
  output logic                       rx_valid_o,
  input  logic                       rx_ready_i,
  output logic [7:0]                 rx_byte_o,
  output logic [$clog2(DEPTH):0]     rx_level_o,
  input  logic                       cmd_start_i,
  input  logic [$clog2(DEPTH):0]     cmd_len_i,
  output logic                       busy_o,
  output logic                       burst_done_o,
  output logic                       spi_start_o,
  output logic [7:0]                 spi_tx_data_o,
  input  logic [7:0]                 spi_rx_data_i,
  input  logic                       spi_done_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW:0]     remaining_q, remaining_d;
  logic            spi_start_q, busy_q, burst_done_q;
  logic [7:0]      spi_tx_data_q;

  logic [7:0]      tx_mem_q [DEPTH];
  logic [AW-1:0]   tx_wr_q, tx_rd_q;
  logic [AW:0]     tx_lvl_q;
  logic            tx_push_s, tx_pop_s;

  logic [7:0]      rx_mem_q [DEPTH];
  logic [AW-1:0]   rx_wr_q, rx_rd_q;
  logic [AW:0]     rx_lvl_q;
  logic            rx_push_s, rx_pop_s;

  logic            load_ok_s;

  assign tx_ready_o = (tx_lvl_q < FULL_LVL);
  assign tx_level_o = tx_lvl_q;
  assign tx_push_s  = tx_valid_i && tx_ready_o;

  assign rx_valid_o = (rx_lvl_q != {(AW+1){1'b0}});
  assign rx_level_o = rx_lvl_q;
  assign rx_byte_o  = rx_mem_q[rx_rd_q];
  assign rx_pop_s   = rx_valid_o && rx_ready_i;

  // A transaction may only be launched when it has a byte to send and a slot for its reply.
  assign load_ok_s  = (tx_lvl_q != {(AW+1){1'b0}}) && (rx_lvl_q < FULL_LVL);

  assign busy_o        = busy_q;
  assign burst_done_o  = burst_done_q;
  assign spi_start_o   = spi_start_q;
  assign spi_tx_data_o = spi_tx_data_q;

  // TX storage write port
  always_ff @(posedge clk_i) begin
    if (tx_push_s) begin
      tx_mem_q[tx_wr_q] <= tx_byte_i;
    end
  end

  // TX pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wr_q  <= {AW{1'b0}};
      tx_rd_q  <= {AW{1'b0}};
      tx_lvl_q <= {(AW+1){1'b0}};
    end else begin
      if (tx_push_s) begin
        tx_wr_q <= tx_wr_q + PTR_ONE;
      end
      if (tx_pop_s) begin
        tx_rd_q <= tx_rd_q + PTR_ONE;
      end
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_lvl_q <= tx_lvl_q + LVL_ONE;
        2'b01:   tx_lvl_q <= tx_lvl_q - LVL_ONE;
        default: tx_lvl_q <= tx_lvl_q;
      endcase
    end
  end

  // RX storage write port
  always_ff @(posedge clk_i) begin
    if (rx_push_s) begin
      rx_mem_q[rx_wr_q] <= spi_rx_data_i;
    end
  end

  // RX pointers and occupancy; a concurrent push and pop leaves the level unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_wr_q  <= {AW{1'b0}};
      rx_rd_q  <= {AW{1'b0}};
      rx_lvl_q <= {(AW+1){1'b0}};
    end else begin
      if (rx_push_s) begin
        rx_wr_q <= rx_wr_q + PTR_ONE;
      end
      if (rx_pop_s) begin
        rx_rd_q <= rx_rd_q + PTR_ONE;
      end
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_lvl_q <= rx_lvl_q + LVL_ONE;
        2'b01:   rx_lvl_q <= rx_lvl_q - LVL_ONE;
        default: rx_lvl_q <= rx_lvl_q;
      endcase
    end
  end

  // Sequencer next-state, FIFO handshakes and burst countdown
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tx_pop_s    = 1'b0;
    rx_push_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_start_i) begin
          remaining_d = cmd_len_i;
          if (cmd_len_i == {(AW+1){1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (load_ok_s) begin
          tx_pop_s = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_LOAD;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done_i) begin
          rx_push_s   = 1'b1;
          remaining_d = remaining_q - LVL_ONE;
          if (remaining_q == LVL_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, countdown and Moore outputs registered from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      remaining_q   <= {(AW+1){1'b0}};
      spi_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      burst_done_q  <= 1'b0;
      spi_tx_data_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      spi_start_q   <= (state_d == S_ISSUE);
      busy_q        <= (state_d != S_IDLE);
      burst_done_q  <= (state_d == S_DONE);
      if (tx_pop_s) begin
        spi_tx_data_q <= tx_mem_q[tx_rd_q];
      end else begin
        spi_tx_data_q <= spi_tx_data_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Scoreboard bench for spi_burst_sequencer with a 20-cycle-latency SPI master model.
module tb_spi_burst_sequencer;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, tx_valid, tx_ready, rx_valid, rx_ready, cmd_start;
  logic          busy, burst_done, spi_start, spi_done;
  logic [7:0]    tx_byte, rx_byte, spi_tx_data, spi_rx_data;
  logic [AW:0]   tx_level, rx_level, cmd_len;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] mst_rx_q[$];
  int starts_cnt = 0, dones_cnt = 0, cyc = 0, mst_cnt = 0, done_cyc = -100;
  bit chk_lat = 1'b0, stray_pend = 1'b0;

  spi_burst_sequencer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_byte_i(tx_byte), .tx_level_o(tx_level),
    .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_byte_o(rx_byte), .rx_level_o(rx_level),
    .cmd_start_i(cmd_start), .cmd_len_i(cmd_len), .busy_o(busy), .burst_done_o(burst_done),
    .spi_start_o(spi_start), .spi_tx_data_o(spi_tx_data),
    .spi_rx_data_i(spi_rx_data), .spi_done_i(spi_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: master model answers, spi_start/burst_done are observed and scored.
  task automatic monitor_step();
    cyc++;
    spi_done = 1'b0;
    if (rst) begin
      mst_cnt = 0;
    end else if (stray_pend) begin
      spi_done = 1'b1;
      spi_rx_data = 8'hEE;
      stray_pend = 1'b0;
    end else if (mst_cnt > 0) begin
      mst_cnt--;
      if (mst_cnt == 0) begin
        spi_done = 1'b1;
        if (mst_rx_q.size() > 0) spi_rx_data = mst_rx_q.pop_front();
        else begin
          spi_rx_data = 8'h00;
          check_eq("mst_resp_avail", 32'(mst_rx_q.size()), 32'd1);
        end
        exp_rx_q.push_back(spi_rx_data);
        done_cyc = cyc;
      end
    end
    if (burst_done) dones_cnt++;
    if (spi_start) begin
      starts_cnt++;
      if (chk_lat && done_cyc >= 0) check_eq("restart_lat", 32'(cyc - done_cyc), 32'd2);
      if (exp_tx_q.size() > 0) check_eq("spi_tx_data", {24'd0, spi_tx_data}, {24'd0, exp_tx_q.pop_front()});
      else check_eq("tx_sb_nonempty", 32'(exp_tx_q.size()), 32'd1);
      if (!rst) mst_cnt = 20;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b, input logic exp_acc);
    tx_valid = 1'b1;
    tx_byte  = b;
    check_eq("tx_ready", {31'd0, tx_ready}, {31'd0, exp_acc});
    if (exp_acc) exp_tx_q.push_back(b);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic cmd(input int len);
    cmd_start = 1'b1;
    cmd_len   = (AW+1)'(len);
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (burst_done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (spi_start) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic pop_rx(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      check_eq("rx_valid", {31'd0, rx_valid}, 32'd1);
      if (exp_rx_q.size() > 0) begin
        e = exp_rx_q.pop_front();
        check_eq("rx_byte", {24'd0, rx_byte}, {24'd0, e});
      end else begin
        check_eq("rx_sb_nonempty", 32'(exp_rx_q.size()), 32'd1);
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
  endtask

  task automatic burst(input int len, input logic [7:0] txb, input logic [7:0] rxb);
    for (int i = 0; i < len; i++) begin
      push_tx(txb + 8'(i), 1'b1);
      mst_rx_q.push_back(rxb + 8'(i));
    end
    cmd(len);
    wait_done("burst_done", len * 30 + 20);
    tick();
    check_eq("busy_after", {31'd0, busy}, 32'd0);
    pop_rx(len);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_tx_level"}, 32'(tx_level), 32'd0);
    check_eq({tag, "_rx_level"}, 32'(rx_level), 32'd0);
    check_eq({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    check_eq({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_burst_done"}, {31'd0, burst_done}, 32'd0);
    check_eq({tag, "_spi_start"}, {31'd0, spi_start}, 32'd0);
    check_eq({tag, "_spi_tx_data"}, {24'd0, spi_tx_data}, 32'd0);
  endtask

  initial begin
    int s0;
    rst = 1'b1; tx_valid = 1'b0; tx_byte = 8'h00; rx_ready = 1'b0;
    cmd_start = 1'b0; cmd_len = '0; spi_done = 1'b0; spi_rx_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    // 3-byte burst with latency checks
    push_tx(8'hA5, 1'b1); push_tx(8'h3C, 1'b1); push_tx(8'hFF, 1'b1);
    check_eq("tx_level3", 32'(tx_level), 32'd3);
    mst_rx_q.push_back(8'h11); mst_rx_q.push_back(8'h22); mst_rx_q.push_back(8'h33);
    s0 = starts_cnt;
    chk_lat = 1'b1;
    cmd(3);
    check_eq("lat_busy_t1", {31'd0, busy}, 32'd1);
    check_eq("lat_nostart_t1", {31'd0, spi_start}, 32'd0);
    tick();
    check_eq("lat_start_t2", {31'd0, spi_start}, 32'd1);
    check_eq("lat_txdata_t2", {24'd0, spi_tx_data}, 32'hA5);
    wait_done("b3_done", 120);
    check_eq("b3_rx_level", 32'(rx_level), 32'd3);
    chk_lat = 1'b0;
    tick();
    check_eq("b3_busy_low", {31'd0, busy}, 32'd0);
    check_eq("b3_starts", 32'(starts_cnt - s0), 32'd3);
    check_eq("b3_dones", 32'(dones_cnt), 32'd1);
    pop_rx(3);

    // Underflow stall in LOAD
    push_tx(8'h5A, 1'b1);
    mst_rx_q.push_back(8'h44); mst_rx_q.push_back(8'h55);
    s0 = starts_cnt;
    cmd(2);
    for (int i = 0; i < 60 && rx_level != 4'd1; i++) tick();
    repeat (100) tick();
    check_eq("stall_starts", 32'(starts_cnt - s0), 32'd1);
    check_eq("stall_busy", {31'd0, busy}, 32'd1);
    check_eq("stall_rx_level", 32'(rx_level), 32'd1);
    push_tx(8'h6B, 1'b1);
    wait_done("stall_done", 80);
    check_eq("stall_starts2", 32'(starts_cnt - s0), 32'd2);
    tick();
    pop_rx(2);

    // Zero-length burst
    s0 = starts_cnt;
    cmd(0);
    check_eq("len0_done_t1", {31'd0, burst_done}, 32'd1);
    tick();
    check_eq("len0_done_clr", {31'd0, burst_done}, 32'd0);
    check_eq("len0_busy", {31'd0, busy}, 32'd0);
    check_eq("len0_starts", 32'(starts_cnt - s0), 32'd0);

    // cmd_start while busy is ignored
    push_tx(8'h71, 1'b1); push_tx(8'h72, 1'b1);
    mst_rx_q.push_back(8'hA1); mst_rx_q.push_back(8'hA2);
    s0 = starts_cnt;
    cmd(2);
    wait_start("ign_start", 10);
    repeat (3) tick();
    cmd(5);
    wait_done("ign_done", 80);
    repeat (40) tick();
    check_eq("ign_starts", 32'(starts_cnt - s0), 32'd2);
    check_eq("ign_busy", {31'd0, busy}, 32'd0);
    pop_rx(2);

    // RX full backpressure
    for (int i = 0; i < 8; i++) begin
      push_tx(8'h20 + 8'(i), 1'b1);
      mst_rx_q.push_back(8'hC0 + 8'(i));
    end
    cmd(8);
    wait_done("full_done", 260);
    check_eq("full_rx_level", 32'(rx_level), 32'd8);
    push_tx(8'h28, 1'b1);
    mst_rx_q.push_back(8'hC8);
    s0 = starts_cnt;
    cmd(1);
    repeat (50) tick();
    check_eq("full_stall_starts", 32'(starts_cnt - s0), 32'd0);
    check_eq("full_stall_busy", {31'd0, busy}, 32'd1);
    pop_rx(1);
    wait_done("full_rel_done", 60);
    check_eq("full_rx_back8", 32'(rx_level), 32'd8);
    tick();
    pop_rx(1);
    // host pop in the same cycle as the sequencer's RX push
    push_tx(8'h29, 1'b1);
    mst_rx_q.push_back(8'hC9);
    cmd(1);
    wait_start("conc_start", 10);
    repeat (20) tick();
    check_eq("conc_rx_level_pre", 32'(rx_level), 32'd7);
    pop_rx(1);
    check_eq("conc_rx_level", 32'(rx_level), 32'd7);
    check_eq("conc_done", {31'd0, burst_done}, 32'd1);
    tick();
    pop_rx(exp_rx_q.size());
    check_eq("conc_drained", 32'(rx_level), 32'd0);

    // FIFO wrap: 20 bytes as 8,8,4, plus a dropped push while TX is full
    for (int i = 0; i < 8; i++) begin
      push_tx(8'h40 + 8'(i), 1'b1);
      mst_rx_q.push_back(8'h90 + 8'(i));
    end
    check_eq("tx_full_level", 32'(tx_level), 32'd8);
    push_tx(8'hEE, 1'b0);
    check_eq("tx_drop_level", 32'(tx_level), 32'd8);
    cmd(8);
    wait_done("wrap1_done", 260);
    tick();
    pop_rx(8);
    burst(8, 8'h48, 8'h98);
    burst(4, 8'h50, 8'hA0);

    // Reset while waiting on the master
    push_tx(8'h61, 1'b1); push_tx(8'h62, 1'b1);
    mst_rx_q.push_back(8'hB1);
    cmd(1);
    wait_start("rst_start", 10);
    repeat (3) tick();
    check_eq("rst_in_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    mst_rx_q.delete();
    exp_tx_q.delete();
    stray_pend = 1'b1;
    repeat (3) tick();
    check_eq("stray_rx_level", 32'(rx_level), 32'd0);
    check_eq("stray_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("stray_busy", {31'd0, busy}, 32'd0);
    exp_rx_q.delete();
    burst(1, 8'h77, 8'hD7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1);
  end
endmodule
